// File: rtl/b_history_update_pkg.sv
// ---------------------------------------------------------------------------
// b_pkg
//   Shared constants and helpers for the branch-history update stage.
//   GHR entry layout: bit TAKEN_BIT = taken flag, bits [8:TAG_LSB] = PC hash tag.
//   GHR layout: entry j at [j*ENTRY_W +: ENTRY_W], j = 0 youngest.
// ---------------------------------------------------------------------------
package b_pkg;

   localparam int GHR_DEPTH  = 20;
   localparam int ENTRY_W    = 9;
   localparam int PUSH_MAX   = 4;
   localparam int FIFO_DEPTH = 16;

   localparam int TAKEN_BIT  = 0;
   localparam int TAG_LSB    = 1;

   localparam int GHR_W      = GHR_DEPTH * ENTRY_W;
   localparam int PUSH_W     = PUSH_MAX * ENTRY_W;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);

   typedef logic [ENTRY_W-1:0] entry_t;

   // Shift a GHR up by n entries and insert the n new ones. Entry k of the
   // bundle is k-th oldest in program order, so the youngest (k = n-1) ends
   // up at index 0 and entry 0 at index n-1. Entries past GHR_DEPTH-1 drop.
   function automatic logic [GHR_W-1:0] ghr_shift_in(
      input logic [GHR_W-1:0]  ghr,
      input logic [PUSH_W-1:0] ent,
      input logic [2:0]        n
   );
      logic [GHR_W-1:0] r;
      r = ghr << (int'(n) * ENTRY_W);
      for (int j = 0; j < PUSH_MAX; j++) begin
         if (j < int'(n)) begin
            r[j*ENTRY_W +: ENTRY_W] = ent[(int'(n) - 1 - j)*ENTRY_W +: ENTRY_W];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/b_history_update_if.sv
// ---------------------------------------------------------------------------
// b_history_update_if
//   Bundles the predictor/execute-facing signals of b_history_update.
//   master : predictor + execute side (drives pushes/resolves, reads GHRs)
//   slave  : b_history_update
//   i_newGHREntry_36 / i_pushNum_3     : predicted entries and their count
//   i_resolveValid_1 / i_resolveTaken_1: execute resolution of oldest B
//   o_globalHistoryRegister_180        : speculative GHR
//   o_retiredGHR_180                   : retired GHR
//   o_pendingB_5 / o_ready_1           : FIFO occupancy / room for 4 more
//   o_flush_1 / o_overflow_1 / o_resolveErr_1 : status flags
// ---------------------------------------------------------------------------
interface b_history_update_if;
   import b_pkg::*;

   logic [PUSH_W-1:0] i_newGHREntry_36;
   logic [2:0]        i_pushNum_3;
   logic              i_resolveValid_1;
   logic              i_resolveTaken_1;
   logic [GHR_W-1:0]  o_globalHistoryRegister_180;
   logic [GHR_W-1:0]  o_retiredGHR_180;
   logic [CNT_W-1:0]  o_pendingB_5;
   logic              o_ready_1;
   logic              o_flush_1;
   logic              o_overflow_1;
   logic              o_resolveErr_1;

   modport master (
      output i_newGHREntry_36, i_pushNum_3, i_resolveValid_1, i_resolveTaken_1,
      input  o_globalHistoryRegister_180, o_retiredGHR_180, o_pendingB_5,
             o_ready_1, o_flush_1, o_overflow_1, o_resolveErr_1
   );

   modport slave (
      input  i_newGHREntry_36, i_pushNum_3, i_resolveValid_1, i_resolveTaken_1,
      output o_globalHistoryRegister_180, o_retiredGHR_180, o_pendingB_5,
             o_ready_1, o_flush_1, o_overflow_1, o_resolveErr_1
   );

endinterface

// File: rtl/b_history_update_pending_b_fifo.sv
// ---------------------------------------------------------------------------
// pending_b_fifo
//   Circular buffer of predicted-but-unresolved B entries.
//   Multi-push (0..PUSH_MAX per cycle, entry 0 first), single pop, sync flush.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_flush_1          : empty the FIFO (wins over push/pop)
//   i_pushNum_3        : entries to append (caller guarantees they fit)
//   i_pushData_36      : entries, k-th at [k*9 +: 9]
//   i_pop_1            : drop head (caller guarantees non-empty)
//   o_head_9           : oldest entry
//   o_count_5, o_free_5: occupancy and free slots
// ---------------------------------------------------------------------------
module pending_b_fifo
   import b_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flush_1,
   input  logic [2:0]        i_pushNum_3,
   input  logic [PUSH_W-1:0] i_pushData_36,
   input  logic              i_pop_1,
   output entry_t            o_head_9,
   output logic [CNT_W-1:0]  o_count_5,
   output logic [CNT_W-1:0]  o_free_5
);

   entry_t           mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (i_flush_1) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         // Pointers wrap naturally at PTR_W bits.
         rd_d  = rd_q + PTR_W'(i_pop_1);
         wr_d  = wr_q + PTR_W'(i_pushNum_3);
         cnt_d = cnt_q - CNT_W'(i_pop_1) + CNT_W'(i_pushNum_3);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage is not reset; only slots covered by the count are ever read.
   always_ff @(posedge i_clk) begin
      if (!i_flush_1) begin
         for (int k = 0; k < PUSH_MAX; k++) begin
            if (k < int'(i_pushNum_3)) begin
               mem_q[wr_q + PTR_W'(k)] <= i_pushData_36[k*ENTRY_W +: ENTRY_W];
            end
         end
      end
   end

   assign o_head_9  = mem_q[rd_q];
   assign o_count_5 = cnt_q;
   assign o_free_5  = CNT_W'(FIFO_DEPTH) - cnt_q;

endmodule

// File: rtl/b_history_update.sv
// ---------------------------------------------------------------------------
// b_history_update
//   Keeps the speculative GHR (read by the predictor), the retired GHR
//   (execute-confirmed outcomes) and the pending-B FIFO. On a mispredicted
//   resolve the speculative GHR is rebuilt from retired history, the FIFO is
//   cleared, same-cycle pushes are discarded and o_flush_1 pulses.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : pushes, resolves, GHR outputs and status flags
// ---------------------------------------------------------------------------
module b_history_update
   import b_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   b_history_update_if.slave  bus
);

   logic [GHR_W-1:0] spec_q, spec_d;
   logic [GHR_W-1:0] ret_q,  ret_d;
   logic             flush_q, flush_d;
   logic             ovf_q,   ovf_d;
   logic             err_q,   err_d;

   entry_t           head;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] free;

   logic [2:0]       n_raw;
   logic [2:0]       n_eff;
   logic             resolve_ok;
   logic             mis;
   logic             too_many;
   entry_t           retire_ent;

   always_comb begin
      // Out-of-range push counts are ignored rather than truncated.
      n_raw      = (bus.i_pushNum_3 > 3'(PUSH_MAX)) ? 3'd0 : bus.i_pushNum_3;
      resolve_ok = bus.i_resolveValid_1 && (count != '0);
      mis        = resolve_ok && (bus.i_resolveTaken_1 != head[TAKEN_BIT]);
      // A same-cycle pop frees one slot for the push.
      too_many   = {3'b000, n_raw} > ({1'b0, free} + {{CNT_W{1'b0}}, resolve_ok});
      n_eff      = (mis || too_many) ? 3'd0 : n_raw;
      retire_ent = {head[ENTRY_W-1:TAG_LSB], bus.i_resolveTaken_1};

      ret_d   = ret_q;
      if (resolve_ok) begin
         ret_d = ghr_shift_in(ret_q, {{(PUSH_W-ENTRY_W){1'b0}}, retire_ent}, 3'd1);
      end

      spec_d  = mis ? ret_d : ghr_shift_in(spec_q, bus.i_newGHREntry_36, n_eff);
      flush_d = mis;
      err_d   = bus.i_resolveValid_1 && (count == '0);
      // Wrong-path pushes are discarded, not counted as overflow.
      ovf_d   = ovf_q || (too_many && !mis);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         spec_q  <= '0;
         ret_q   <= '0;
         flush_q <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         spec_q  <= spec_d;
         ret_q   <= ret_d;
         flush_q <= flush_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   pending_b_fifo u_fifo (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_flush_1     (mis),
      .i_pushNum_3   (n_eff),
      .i_pushData_36 (bus.i_newGHREntry_36),
      .i_pop_1       (resolve_ok),
      .o_head_9      (head),
      .o_count_5     (count),
      .o_free_5      (free)
   );

   assign bus.o_globalHistoryRegister_180 = spec_q;
   assign bus.o_retiredGHR_180            = ret_q;
   assign bus.o_pendingB_5                = count;
   assign bus.o_ready_1                   = (free >= CNT_W'(PUSH_MAX));
   assign bus.o_flush_1                   = flush_q;
   assign bus.o_overflow_1                = ovf_q;
   assign bus.o_resolveErr_1              = err_q;

endmodule
